// File: rtl/axi_4_lite_mst_if.sv
// AXI4-Lite bus bundle between axi_4_lite_mst and a register-file slave.
// Protection signals are omitted because the slave ties them to zero.
interface axi_4_lite_mst_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [STRB_W-1:0]     M_AXI_WSTRB;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;

    modport master (
        output M_AXI_AWVALID, M_AXI_AWADDR,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY,
        output M_AXI_ARVALID, M_AXI_ARADDR,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWVALID, M_AXI_AWADDR,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY,
        input  M_AXI_ARVALID, M_AXI_ARADDR,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite master: turns a one-outstanding command/response port into AW+W->B
// write and AR->R read transactions, with a per-state watchdog pulse.
module axi_4_lite_mst #(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int STRB_W         = DATA_WIDTH / 8
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    input  logic [STRB_W-1:0]     CMD_WSTRB,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    output logic                  TIMEOUT,
    axi_4_lite_mst_if.master      m_axi
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t                state_reg, state_next;
    logic                  cmd_ready_reg, cmd_ready_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0]     strb_reg, strb_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;
    logic                  aw_done_reg, aw_done_next;
    logic                  w_done_reg, w_done_next;
    logic                  bready_reg, bready_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  rready_reg, rready_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]            rsp_resp_reg, rsp_resp_next;
    logic [CNT_W-1:0]      wd_cnt_reg, wd_cnt_next;
    logic                  timeout_reg, timeout_next;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic aw_all;
    logic w_all;
    logic waiting;

    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        strb_next      = strb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
        wd_cnt_next    = wd_cnt_reg;
        timeout_next   = 1'b0;

        accept = CMD_VALID & cmd_ready_reg;
        aw_hs  = awvalid_reg & m_axi.M_AXI_AWREADY;
        w_hs   = wvalid_reg & m_axi.M_AXI_WREADY;
        aw_all = aw_done_reg | aw_hs;
        w_all  = w_done_reg | w_hs;

        case (state_reg)
            IDLE: begin
                // CMD_READY is registered, so it first rises one edge after reset.
                cmd_ready_next = ~accept;
                if (accept) begin
                    addr_next  = CMD_ADDR;
                    wdata_next = CMD_WDATA;
                    strb_next  = CMD_WSTRB;
                    if (CMD_WRITE) begin
                        state_next   = WR_AW_W;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                    end else begin
                        state_next   = RD_AR;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if (aw_all && w_all) begin
                    state_next  = WR_B;
                    bready_next = 1'b1;
                end
            end
            WR_B: begin
                if (m_axi.M_AXI_BVALID && bready_reg) begin
                    bready_next    = 1'b0;
                    rsp_resp_next  = m_axi.M_AXI_BRESP;
                    rsp_rdata_next = '0;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RD_AR: begin
                if (arvalid_reg && m_axi.M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_R;
                end
            end
            RD_R: begin
                if (m_axi.M_AXI_RVALID && rready_reg) begin
                    rready_next    = 1'b0;
                    rsp_rdata_next = m_axi.M_AXI_RDATA;
                    rsp_resp_next  = m_axi.M_AXI_RRESP;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (rsp_valid_reg && RSP_READY) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Watchdog: restarts on every state change, saturates at the limit and
        // flags only the cycle in which the limit is first reached.
        waiting = (state_reg == WR_AW_W) || (state_reg == WR_B) ||
                  (state_reg == RD_AR)   || (state_reg == RD_R);
        if (state_next != state_reg) begin
            wd_cnt_next = '0;
        end else if (waiting && (wd_cnt_reg != WD_LIMIT)) begin
            wd_cnt_next = wd_cnt_reg + CNT_W'(1);
        end
        timeout_next = (TIMEOUT_CYCLES != 0) && (wd_cnt_next == WD_LIMIT) &&
                       (wd_cnt_reg != WD_LIMIT);
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            strb_reg      <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
            wd_cnt_reg    <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            strb_reg      <= strb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
            wd_cnt_reg    <= wd_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign CMD_READY = cmd_ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_RESP  = rsp_resp_reg;
    assign TIMEOUT   = timeout_reg;

    assign m_axi.M_AXI_AWVALID = awvalid_reg;
    assign m_axi.M_AXI_AWADDR  = addr_reg;
    assign m_axi.M_AXI_WVALID  = wvalid_reg;
    assign m_axi.M_AXI_WDATA   = wdata_reg;
    assign m_axi.M_AXI_WSTRB   = strb_reg;
    assign m_axi.M_AXI_BREADY  = bready_reg;
    assign m_axi.M_AXI_ARVALID = arvalid_reg;
    assign m_axi.M_AXI_ARADDR  = addr_reg;
    assign m_axi.M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Directed bench for axi_4_lite_mst against a small AXI4-Lite register-file slave
// model with programmable ready stalls and response codes.
module tb_axi_4_lite_mst;

    logic        clk = 1'b0;
    logic        arst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;
    int rsp_count = 0;

    int          cfg_aw_stall = 0;
    int          cfg_w_stall  = 0;
    int          cfg_ar_stall = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [1:0]  cfg_rresp    = 2'b00;

    always #5 clk = ~clk;

    axi_4_lite_mst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_4_lite_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(256)) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (arst),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_WRITE    (cmd_write),
        .CMD_ADDR     (cmd_addr),
        .CMD_WDATA    (cmd_wdata),
        .CMD_WSTRB    (cmd_wstrb),
        .RSP_VALID    (rsp_valid),
        .RSP_READY    (rsp_ready),
        .RSP_RDATA    (rsp_rdata),
        .RSP_RESP     (rsp_resp),
        .TIMEOUT      (timeout),
        .m_axi        (bus)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [0:31];
    logic        aw_got, w_got, bvalid_q, rvalid_q;
    logic [31:0] aw_addr_q, w_data_q, rdata_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, rresp_q;
    int          aw_wait, w_wait, ar_wait;
    logic        hs_aw, hs_w, hs_ar, wr_fire;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign bus.M_AXI_AWREADY = !aw_got && !bvalid_q && (aw_wait >= cfg_aw_stall);
    assign bus.M_AXI_WREADY  = !w_got && !bvalid_q && (w_wait >= cfg_w_stall);
    assign bus.M_AXI_ARREADY = !rvalid_q && (ar_wait >= cfg_ar_stall);
    assign bus.M_AXI_BVALID  = bvalid_q;
    assign bus.M_AXI_BRESP   = bresp_q;
    assign bus.M_AXI_RVALID  = rvalid_q;
    assign bus.M_AXI_RDATA   = rdata_q;
    assign bus.M_AXI_RRESP   = rresp_q;

    always_comb begin
        hs_aw   = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
        hs_w    = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
        hs_ar   = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
        wr_fire = (aw_got || hs_aw) && (w_got || hs_w);
        wr_addr = aw_got ? aw_addr_q : bus.M_AXI_AWADDR;
        wr_data = w_got ? w_data_q : bus.M_AXI_WDATA;
        wr_strb = w_got ? w_strb_q : bus.M_AXI_WSTRB;
    end

    always @(posedge clk) begin
        if (arst) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            bresp_q <= 2'b00; rresp_q <= 2'b00; rdata_q <= 32'h0;
        end else begin
            if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) aw_wait <= aw_wait + 1;
            else if (hs_aw) aw_wait <= 0;
            if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) w_wait <= w_wait + 1;
            else if (hs_w) w_wait <= 0;
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ar_wait <= ar_wait + 1;
            else if (hs_ar) ar_wait <= 0;

            if (wr_fire) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= cfg_bresp;
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[6:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end else begin
                if (hs_aw) begin aw_got <= 1'b1; aw_addr_q <= bus.M_AXI_AWADDR; end
                if (hs_w)  begin w_got <= 1'b1; w_data_q <= bus.M_AXI_WDATA; w_strb_q <= bus.M_AXI_WSTRB; end
            end
            if (bvalid_q && bus.M_AXI_BREADY) bvalid_q <= 1'b0;

            if (hs_ar) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem[bus.M_AXI_ARADDR[6:2]];
                rresp_q  <= cfg_rresp;
            end else if (rvalid_q && bus.M_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always @(posedge clk) if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_ready_wait", {127'h0, cmd_ready}, 128'h1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("issue %s addr=%h data=%h strb=%b", w ? "WR" : "RD", a, d, s);
    endtask

    // lat counts negedges from the accept edge; exp_lat <= 0 skips the latency check.
    task automatic finish(input string tag, input logic [31:0] exp_rd, input logic [1:0] exp_rs,
                          input int exp_lat, input int hold);
        int lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        check({tag, "_valid"}, {127'h0, rsp_valid}, 128'h1);
        if (exp_lat > 0) check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, {94'h0, rsp_rdata, rsp_resp}, {94'h0, exp_rd, exp_rs});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold"}, {92'h0, rsp_valid, cmd_ready, rsp_rdata, rsp_resp},
                  {92'h0, 1'b1, 1'b0, exp_rd, exp_rs});
        end
        $display("rsp %s rdata=%h resp=%b lat=%0d", tag, rsp_rdata, rsp_resp, lat);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int t_hits, t_pos;
        logic t_arv;

        arst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {120'h0, cmd_ready, rsp_valid, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
              bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, timeout}, 128'h0);
        check("reset_data", {26'h0, rsp_rdata, rsp_resp, bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB},
              128'h0);
        arst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", {127'h0, cmd_ready}, 128'h1);

        // T1: zero-wait write then read
        issue(1'b1, 32'h00, 32'hDEADBEEF, 4'b1111);
        check("t1_aw_w_same_cycle", {123'h0, bus.M_AXI_AWVALID, bus.M_AXI_AWREADY,
              bus.M_AXI_WVALID, bus.M_AXI_WREADY, cmd_ready}, {123'h0, 5'b11110});
        finish("t1_wr", 32'h0, 2'b00, 3, 0);
        issue(1'b0, 32'h00, 32'h0, 4'b0000);
        finish("t1_rd", 32'hDEADBEEF, 2'b00, 3, 0);

        // T2: byte-strobe merge and top-of-map address
        issue(1'b1, 32'h14, 32'hFFFFFFFF, 4'b1111);
        finish("t2_wr_full", 32'h0, 2'b00, 3, 0);
        issue(1'b1, 32'h14, 32'h00563400, 4'b0110);
        finish("t2_wr_part", 32'h0, 2'b00, 3, 0);
        issue(1'b0, 32'h14, 32'h0, 4'b0000);
        finish("t2_rd_merge", 32'hFF5634FF, 2'b00, 3, 0);
        issue(1'b1, 32'h7C, 32'hA5A5A5A5, 4'b1111);
        finish("t2_wr_7c", 32'h0, 2'b00, 3, 0);
        issue(1'b0, 32'h7C, 32'h0, 4'b0000);
        finish("t2_rd_7c", 32'hA5A5A5A5, 2'b00, 3, 0);

        // T3: W stalled 10 cycles, SLVERR passed through, response back-pressured
        cfg_w_stall = 10; cfg_bresp = 2'b10;
        c0 = rsp_count;
        issue(1'b1, 32'h20, 32'h12345678, 4'b1111);
        check("t3_first_cycle", {124'h0, bus.M_AXI_AWVALID, bus.M_AXI_AWREADY,
              bus.M_AXI_WVALID, bus.M_AXI_WREADY}, {124'h0, 4'b1110});
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            check("t3_w_stall", {88'h0, bus.M_AXI_WVALID, bus.M_AXI_WREADY, bus.M_AXI_AWVALID,
                  bus.M_AXI_BREADY, bus.M_AXI_WDATA, bus.M_AXI_WSTRB},
                  {88'h0, 4'b1000, 32'h12345678, 4'b1111});
        end
        finish("t3_wr", 32'h0, 2'b10, 0, 5);
        repeat (3) @(negedge clk);
        check("t3_one_rsp", 128'(rsp_count - c0), 128'h1);
        cfg_w_stall = 0; cfg_bresp = 2'b00;
        issue(1'b0, 32'h20, 32'h0, 4'b0000);
        finish("t3_rd", 32'h12345678, 2'b00, 3, 0);

        // T4: AR stalled past the watchdog, then reset mid-wait
        cfg_ar_stall = 300;
        c0 = rsp_count;
        t_hits = 0; t_pos = 0; t_arv = 1'b0;
        issue(1'b0, 32'h14, 32'h0, 4'b0000);
        for (int n = 1; n <= 290; n++) begin
            if (n > 1) @(negedge clk);
            if (timeout) begin t_hits++; t_pos = n; t_arv = bus.M_AXI_ARVALID; end
        end
        $display("t4 timeout hits=%0d pos=%0d arvalid=%0b", t_hits, t_pos, t_arv);
        check("t4_timeout_hits", 128'(t_hits), 128'h1);
        check("t4_timeout_pos", 128'(t_pos), 128'd257);
        check("t4_timeout_arvalid", {127'h0, t_arv}, 128'h1);
        arst = 1'b1;
        @(posedge clk);
        #1;
        check("t4_reset_drop", {124'h0, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, rsp_valid, cmd_ready},
              128'h0);
        @(negedge clk);
        arst = 1'b0; cfg_ar_stall = 0;
        @(negedge clk);
        check("t4_after_reset", {126'h0, cmd_ready, rsp_valid}, {126'h0, 2'b10});
        repeat (3) @(negedge clk);
        check("t4_no_rsp", 128'(rsp_count - c0), 128'h0);
        issue(1'b0, 32'h14, 32'h0, 4'b0000);
        finish("t4_rd_after_reset", 32'hFF5634FF, 2'b00, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
